// File: rtl/vout_udpoti_multi.sv
// Round-robin driver for several X9C-style up/down pots sharing UPDOWN/INCREMENT, one CS_N each.
// Optional VOUT_UDPOTI_STORE_EN: a grant that reaches its target deselects with INC high (NV store).
module vout_udpoti_multi #(
    parameter int CHANNELS   = 2,
    parameter int RESOLUTION = 100,
    parameter int SPEED      = 100000,
    parameter int BURST      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*CHANNELS-1:0] value,
    output logic                   UPDOWN,
    output logic                   INCREMENT,
    output logic [CHANNELS-1:0]    CS_N,
    output logic                   busy
);

    localparam int PW = $clog2(RESOLUTION + 2);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = $clog2(BURST + 2);
    localparam int TW = $clog2(SPEED + 2);

    typedef enum logic [2:0] {
        HOME_SEL,
        HOME_LOW,
        HOME_HIGH,
        IDLE,
        STEP,
        HOLD,
`ifdef VOUT_UDPOTI_STORE_EN
        STORE,
`endif
        REL
    } state_t;

    state_t              state_reg, state_next;
    logic [TW-1:0]       tick_cnt_reg;
    logic                tick;
    logic [PW-1:0]       home_cnt_reg, home_cnt_next;
    logic [BW-1:0]       burst_reg, burst_next;
    logic [CW-1:0]       rr_reg, rr_next, cur_reg, cur_next, pick, rr_adv;
    logic                updown_reg, updown_next;
    logic                inc_reg, inc_next;
    logic                busy_reg, busy_next;
    logic [CHANNELS-1:0] cs_n_reg, cs_n_next;
    logic [CHANNELS-1:0] need_vec, up_vec;
    logic [CW:0]         arb_idx;
    logic                found, hold_go, step_en;

    // Everything else advances only on the cycle the divider reads zero.
    assign tick = (tick_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt_reg <= TW'(SPEED);
        else             tick_cnt_reg <= tick_cnt_reg - 1'b1;
    end

    assign step_en = tick && (state_reg == STEP);

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [PW-1:0] tgt;
        logic [PW-1:0] pos_reg;

        assign tgt = (value[32*gi +: 32] > 32'(RESOLUTION)) ? PW'(RESOLUTION) : value[32*gi +: PW];
        assign need_vec[gi] = (tgt != pos_reg);
        assign up_vec[gi]   = (tgt > pos_reg);

        always_ff @(posedge clk) begin
            if (rst)
                pos_reg <= '0;
            else if (step_en && (cur_reg == CW'(gi)))
                pos_reg <= updown_reg ? pos_reg + 1'b1 : pos_reg - 1'b1;
        end
    end

    // First channel at or after the round-robin pointer that still needs to move.
    always_comb begin
        found   = 1'b0;
        pick    = rr_reg;
        arb_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            arb_idx = {1'b0, rr_reg} + (CW+1)'(i);
            if (arb_idx >= (CW+1)'(CHANNELS)) arb_idx = arb_idx - (CW+1)'(CHANNELS);
            if (!found && need_vec[arb_idx[CW-1:0]]) begin
                found = 1'b1;
                pick  = arb_idx[CW-1:0];
            end
        end
    end

    assign hold_go = need_vec[cur_reg] && (burst_reg < BW'(BURST)) && (up_vec[cur_reg] == updown_reg);
    assign rr_adv  = (cur_reg == CW'(CHANNELS - 1)) ? '0 : cur_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= HOME_SEL;
            home_cnt_reg <= PW'(RESOLUTION);
            burst_reg    <= '0;
            rr_reg       <= '0;
            cur_reg      <= '0;
            updown_reg   <= 1'b0;
            inc_reg      <= 1'b1;
            busy_reg     <= 1'b1;
            cs_n_reg     <= '1;
        end else begin
            state_reg    <= state_next;
            home_cnt_reg <= home_cnt_next;
            burst_reg    <= burst_next;
            rr_reg       <= rr_next;
            cur_reg      <= cur_next;
            updown_reg   <= updown_next;
            inc_reg      <= inc_next;
            busy_reg     <= busy_next;
            cs_n_reg     <= cs_n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                HOME_SEL:  state_next = (RESOLUTION == 0) ? REL : HOME_LOW;
                HOME_LOW:  state_next = HOME_HIGH;
                HOME_HIGH: state_next = (home_cnt_reg != '0) ? HOME_LOW : REL;
                IDLE:      if (found) state_next = STEP;
                STEP:      state_next = HOLD;
                HOLD: begin
                    if (hold_go)                 state_next = STEP;
`ifdef VOUT_UDPOTI_STORE_EN
                    else if (!need_vec[cur_reg]) state_next = STORE;
`endif
                    else                         state_next = REL;
                end
`ifdef VOUT_UDPOTI_STORE_EN
                STORE:     state_next = IDLE;
`endif
                REL:       state_next = IDLE;
                default:   state_next = HOME_SEL;
            endcase
        end
    end

    always_comb begin
        home_cnt_next = home_cnt_reg;
        burst_next    = burst_reg;
        rr_next       = rr_reg;
        cur_next      = cur_reg;
        updown_next   = updown_reg;
        inc_next      = inc_reg;
        busy_next     = busy_reg;
        cs_n_next     = cs_n_reg;
        if (tick) begin
            case (state_reg)
                HOME_SEL: begin
                    updown_next = 1'b0;
                    if (RESOLUTION != 0) cs_n_next = '0;
                end
                HOME_LOW: begin
                    inc_next      = 1'b0;
                    home_cnt_next = home_cnt_reg - 1'b1;
                end
                HOME_HIGH: begin
                    if (home_cnt_reg != '0) inc_next  = 1'b1;
                    else                    cs_n_next = '1;
                end
                IDLE: begin
                    if (found) begin
                        cur_next    = pick;
                        cs_n_next   = ~(CHANNELS'(1) << pick);
                        updown_next = up_vec[pick];
                        burst_next  = '0;
                    end
                end
                STEP: begin
                    inc_next   = 1'b0;
                    burst_next = burst_reg + 1'b1;
                end
                HOLD: begin
                    if (hold_go)                 inc_next = 1'b1;
`ifdef VOUT_UDPOTI_STORE_EN
                    else if (!need_vec[cur_reg]) inc_next = 1'b1;
`endif
                    else                         cs_n_next[cur_reg] = 1'b1;
                end
`ifdef VOUT_UDPOTI_STORE_EN
                STORE: begin
                    cs_n_next[cur_reg] = 1'b1;
                    rr_next            = rr_adv;
                end
`endif
                REL: begin
                    inc_next  = 1'b1;
                    busy_next = 1'b0;
                    // The release that ends homing leaves the pointer alone.
                    if (!busy_reg) rr_next = rr_adv;
                end
                default: ;
            endcase
        end
    end

    assign UPDOWN    = updown_reg;
    assign INCREMENT = inc_reg;
    assign CS_N      = cs_n_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_vout_udpoti_multi.sv
// Directed bench for vout_udpoti_multi: a pin-level pot model tracks wiper positions and grants.
// Expectations for the VOUT_UDPOTI_STORE_EN build follow the same macro.
module tb_vout_udpoti_multi;

    localparam int CH = 2;
`ifdef VOUT_UDPOTI_STORE_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] value = '0;
    logic        UPDOWN, INCREMENT, busy;
    logic [1:0]  CS_N;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vout_udpoti_multi #(
        .CHANNELS(2), .RESOLUTION(4), .SPEED(1), .BURST(2)
    ) dut (
        .clk(clk), .rst(rst), .value(value),
        .UPDOWN(UPDOWN), .INCREMENT(INCREMENT), .CS_N(CS_N), .busy(busy)
    );

    // Pin-level observer: behaves like the pots plus a grant logger.
    logic       prev_inc = 1'b1, prev_ud = 1'b0, had_rise = 1'b0, home_rise_inc = 1'b1;
    logic [1:0] prev_cs = 2'b11;
    int run_len = 0, home_falls = 0, home_ud_hi = 0;
    int home_low_min = 99, home_low_max = 0, home_high_min = 99, home_high_max = 0;
    int overlap = 0, ud_viol = 0, log_n = 0;
    int fall_total[2] = '{0, 0};
    int pot_pos[2] = '{0, 0};
    int grant_falls[2] = '{0, 0};
    int log_code[64];

    always @(negedge clk) begin
        if (rst) begin
            home_falls = 0; home_ud_hi = 0; home_rise_inc = 1'b1; had_rise = 1'b0;
            home_low_min = 99; home_low_max = 0; home_high_min = 99; home_high_max = 0;
            for (int c = 0; c < CH; c++) begin pot_pos[c] = 0; grant_falls[c] = 0; end
        end else begin
            if (UPDOWN != prev_ud && !(INCREMENT && prev_inc)) ud_viol++;
            if (CS_N == 2'b00 && !busy) overlap++;
            if (busy) begin
                for (int c = 0; c < CH; c++) pot_pos[c] = 0;
                if (prev_inc && !INCREMENT && CS_N == 2'b00) begin
                    home_falls++;
                    if (UPDOWN) home_ud_hi++;
                    if (had_rise) begin
                        if (run_len < home_high_min) home_high_min = run_len;
                        if (run_len > home_high_max) home_high_max = run_len;
                    end
                end
                if (!prev_inc && INCREMENT && CS_N == 2'b00) begin
                    if (run_len < home_low_min) home_low_min = run_len;
                    if (run_len > home_low_max) home_low_max = run_len;
                end
                if (prev_cs == 2'b00 && CS_N == 2'b11) home_rise_inc = INCREMENT;
            end else begin
                for (int c = 0; c < CH; c++)
                    if (prev_cs[c] && !CS_N[c]) grant_falls[c] = 0;
                if (prev_inc && !INCREMENT)
                    for (int c = 0; c < CH; c++)
                        if (!CS_N[c]) begin
                            grant_falls[c]++;
                            fall_total[c]++;
                            pot_pos[c] += UPDOWN ? 1 : -1;
                        end
                for (int c = 0; c < CH; c++)
                    if (!prev_cs[c] && CS_N[c] && log_n < 64) begin
                        log_code[log_n] = c * 100 + grant_falls[c] * 10 + int'(INCREMENT);
                        log_n++;
                    end
            end
            if (!prev_inc && INCREMENT) had_rise = 1'b1;
        end
        if (INCREMENT == prev_inc) run_len++;
        else                       run_len = 1;
        prev_inc = INCREMENT;
        prev_ud  = UPDOWN;
        prev_cs  = CS_N;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        value = '0;
        wait_clk(3);
        vectors++; if (UPDOWN !== 1'b0)    begin miscompares++; $display("FAIL reset_updown: got %b want 0", UPDOWN); end
        vectors++; if (INCREMENT !== 1'b1) begin miscompares++; $display("FAIL reset_inc: got %b want 1", INCREMENT); end
        vectors++; if (CS_N !== 2'b11)     begin miscompares++; $display("FAIL reset_cs_n: got %b want 11", CS_N); end
        vectors++; if (busy !== 1'b1)      begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        $display("reset: UPDOWN=%b INCREMENT=%b CS_N=%b busy=%b", UPDOWN, INCREMENT, CS_N, busy);
        rst = 1'b0;
    endtask

    task automatic test_homing();
        int t = 0;
        while (busy === 1'b1 && t < 200) begin wait_clk(1); t++; end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL homing_done: busy=%b want 0 after %0d clk", busy, t); end
        vectors++; if (home_falls != 4)   begin miscompares++; $display("FAIL homing_pulses: got %0d want 4", home_falls); end
        vectors++; if (home_ud_hi != 0)   begin miscompares++; $display("FAIL homing_dir: %0d pulses with UPDOWN=1, want 0", home_ud_hi); end
        vectors++; if (home_low_min != 2 || home_low_max != 2)
            begin miscompares++; $display("FAIL homing_low_len: got %0d..%0d want 2..2", home_low_min, home_low_max); end
        vectors++; if (home_high_min != 2 || home_high_max != 2)
            begin miscompares++; $display("FAIL homing_high_len: got %0d..%0d want 2..2", home_high_min, home_high_max); end
        vectors++; if (home_rise_inc !== 1'b0) begin miscompares++; $display("FAIL homing_deselect_inc: got %b want 0", home_rise_inc); end
        vectors++; if (CS_N !== 2'b11 || INCREMENT !== 1'b1)
            begin miscompares++; $display("FAIL homing_end: CS_N=%b INC=%b want 11/1", CS_N, INCREMENT); end
        $display("homing: %0d pulses in %0d clk", home_falls, t);
    endtask

    // Apply targets, let the arbiter settle, then compare grants and wiper positions.
    task automatic run_case(input string name, input int v0, input int v1, input int n_exp,
                            input int e0, input int e1, input int e2,
                            input int p0, input int p1);
        int l0 = log_n;
        int ov0 = overlap;
        int exp_code[3];
        exp_code[0] = e0; exp_code[1] = e1; exp_code[2] = e2;
        value = {v1[31:0], v0[31:0]};
        wait_clk(100);
        vectors++; if (log_n - l0 != n_exp)
            begin miscompares++; $display("FAIL %s_grants: got %0d want %0d", name, log_n - l0, n_exp); end
        for (int k = 0; k < n_exp && k < log_n - l0; k++) begin
            $display("%s grant %0d: ch=%0d steps=%0d inc_at_release=%0d", name, k,
                     log_code[l0+k] / 100, (log_code[l0+k] / 10) % 10, log_code[l0+k] % 10);
            vectors++; if (log_code[l0+k] != exp_code[k])
                begin miscompares++; $display("FAIL %s_grant%0d: got code %0d want %0d", name, k, log_code[l0+k], exp_code[k]); end
        end
        vectors++; if (pot_pos[0] != p0) begin miscompares++; $display("FAIL %s_pos0: got %0d want %0d", name, pot_pos[0], p0); end
        vectors++; if (pot_pos[1] != p1) begin miscompares++; $display("FAIL %s_pos1: got %0d want %0d", name, pot_pos[1], p1); end
        vectors++; if (overlap != ov0)   begin miscompares++; $display("FAIL %s_overlap: %0d cycles with CS_N=00", name, overlap - ov0); end
        vectors++; if (CS_N !== 2'b11 || INCREMENT !== 1'b1)
            begin miscompares++; $display("FAIL %s_idle: CS_N=%b INC=%b want 11/1", name, CS_N, INCREMENT); end
    endtask

    task automatic test_alternate();
        run_case("alternate", 2, 2, 2, 20 + S, 120 + S, 0, 2, 2);
        run_case("to_zero", 0, 0, 2, 20 + S, 120 + S, 0, 0, 0);
    endtask

    task automatic test_burst();
        run_case("burst", 3, 0, 2, 20, 10 + S, 0, 3, 0);
    endtask

    task automatic test_clamp();
        int f0;
        run_case("clamp", 9, 0, 1, 10 + S, 0, 0, 4, 0);
        f0 = fall_total[0];
        wait_clk(50);
        vectors++; if (fall_total[0] != f0)
            begin miscompares++; $display("FAIL clamp_quiet: %0d extra pulses want 0", fall_total[0] - f0); end
    endtask

    task automatic test_reversal();
        int f0 = fall_total[0];
        int t = 0;
        value[31:0] = 32'd0;
        while (fall_total[0] == f0 && t < 60) begin wait_clk(1); t++; end
        vectors++; if (fall_total[0] == f0) begin miscompares++; $display("FAIL reversal_first_step: no pulse in %0d clk", t); end
        vectors++; if (pot_pos[0] != 3)     begin miscompares++; $display("FAIL reversal_mid_pos: got %0d want 3", pot_pos[0]); end
        run_case("reversal", 4, 0, 2, 10, 10 + S, 0, 4, 0);
        vectors++; if (ud_viol != 0) begin miscompares++; $display("FAIL reversal_ud_while_low: %0d changes want 0", ud_viol); end
    endtask

    task automatic test_store();
        run_case("store", 1, 0, 2, 20, 10 + S, 0, 1, 0);
        vectors++; if (log_n < 1 || log_code[log_n-1] % 10 != S)
            begin miscompares++; $display("FAIL store_release_inc: got %0d want %0d", (log_n > 0) ? log_code[log_n-1] % 10 : -1, S); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        value[63:32] = 32'd3;
        while (CS_N[1] !== 1'b0 && t < 40) begin wait_clk(1); t++; end
        vectors++; if (CS_N[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_grant: CS_N=%b want ch1 selected", CS_N); end
        wait_clk(2);
        rst = 1'b1;
        wait_clk(1);
        vectors++; if (CS_N !== 2'b11 || INCREMENT !== 1'b1 || busy !== 1'b1 || UPDOWN !== 1'b0)
            begin miscompares++; $display("FAIL midrst_abort: CS_N=%b INC=%b busy=%b UD=%b want 11/1/1/0", CS_N, INCREMENT, busy, UPDOWN); end
        $display("mid-grant reset: CS_N=%b INCREMENT=%b busy=%b", CS_N, INCREMENT, busy);
        wait_clk(2);
        rst = 1'b0;
        test_homing();
        run_case("rehome", 1, 3, 3, 10 + S, 120, 110 + S, 1, 3);
    endtask

    task automatic test_invariants();
        vectors++; if (ud_viol != 0) begin miscompares++; $display("FAIL ud_while_low: %0d changes want 0", ud_viol); end
        vectors++; if (overlap != 0) begin miscompares++; $display("FAIL cs_overlap: %0d cycles want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_homing();
        test_alternate();
        test_burst();
        test_clamp();
        test_reversal();
        test_store();
        test_reset_mid();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
